// File: rtl/add_sub_seq_ctrl.sv
// rtl/add_sub_seq_ctrl.sv - wide add/sub sequenced one nibble per clock through an external 4-bit adder
module add_sub_seq_ctrl #(
  parameter int NIBBLES = 4,
  localparam int W  = 4 * NIBBLES,
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic [3:0]   dp_a,
  output logic [3:0]   dp_b,
  output logic         dp_cin,
  input  logic [3:0]   dp_sum,
  input  logic         dp_cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic          carry;
  logic          sub_q;
  logic [W-1:0]  a_q, b_q;
  logic [3:0]    a_nib, b_nib;
  logic          accept;
  logic          last;

  always_comb begin
    a_nib     = '0;
    b_nib     = '0;
    state_nxt = state;
    accept    = start && (state != RUN);
    last      = (idx == IW'(NIBBLES - 1));
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
    // B inversion happens here; the datapath is a plain adder
    dp_a   = (state == RUN) ? a_nib : 4'h0;
    dp_b   = (state == RUN) ? (sub_q ? ~b_nib : b_nib) : 4'h0;
    dp_cin = (state == RUN) && carry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sub_q  <= 1'b0;
      idx    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      sub_q  <= sub;
      idx    <= '0;
      carry  <= sub;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (state == RUN) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx == IW'(i)) result[4*i +: 4] <= dp_sum;
      end
      carry <= dp_cout;
      idx   <= last ? '0 : idx + IW'(1);
      if (last) begin
        cout <= dp_cout;
        // dp_a/dp_b MSBs on the last nibble are the operand sign bits
        ovf  <= (dp_a[3] == dp_b[3]) && (dp_sum[3] != dp_a[3]);
      end
    end
  end

endmodule
